// File: rtl/uart_csr_multi_regfile_pkg.sv
// Shared register map, CTRL/STATUS bit positions and field types for the
// multi-channel UART CSR block.
package uart_csr_multi_regfile_pkg;

   localparam int ERRCNT_W = 8;

   localparam logic [1:0] REG_BAUD   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_ERRCNT = 2'd3;

   localparam int CTRL_ENABLE      = 0;
   localparam int CTRL_PARITY_EN   = 1;
   localparam int CTRL_PARITY_ODD  = 2;
   localparam int CTRL_STOP2       = 3;
   localparam int CTRL_IRQ_PERR_EN = 4;
   localparam int CTRL_IRQ_DONE_EN = 5;
   localparam int CTRL_W           = 6;

   localparam int ST_BUSY = 0;
   localparam int ST_FREE = 1;
   localparam int ST_PERR = 2;
   localparam int ST_DONE = 3;

   typedef struct packed {
      logic irq_done_en;
      logic irq_perr_en;
      logic stop2;
      logic parity_odd;
      logic parity_en;
      logic enable;
   } uart_ch_ctrl_t;

endpackage

// File: rtl/uart_csr_chan.sv
// One channel's register slice: BAUD/CTRL storage, sticky perr/done,
// saturating parity-error counter and the registered channel interrupt.
module uart_csr_chan
   import uart_csr_multi_regfile_pkg::*;
#(
   parameter int BAUD_W   = 16,
   parameter int BAUD_RST = 434
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [1:0]          wr_reg,
   input  logic [BAUD_W-1:0]   wdata,
   input  logic                parity_error,
   input  logic                busy,
   output logic [BAUD_W-1:0]   baud,
   output logic [CTRL_W-1:0]   ctrl,
   output logic                perr,
   output logic                done,
   output logic [ERRCNT_W-1:0] errcnt,
   output logic                irq
);

   uart_ch_ctrl_t ctrl_q;
   logic          busy_q;
   logic          wr_baud, wr_ctrl, wr_cnt, w1c_perr, w1c_done, busy_fall;

   assign wr_baud   = wr_en && (wr_reg == REG_BAUD);
   assign wr_ctrl   = wr_en && (wr_reg == REG_CTRL);
   assign wr_cnt    = wr_en && (wr_reg == REG_ERRCNT);
   assign w1c_perr  = wr_en && (wr_reg == REG_STATUS) && wdata[ST_PERR];
   assign w1c_done  = wr_en && (wr_reg == REG_STATUS) && wdata[ST_DONE];
   assign busy_fall = busy_q & ~busy;
   assign ctrl      = ctrl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud   <= BAUD_W'(BAUD_RST);
         ctrl_q <= '0;
         perr   <= 1'b0;
         done   <= 1'b0;
         errcnt <= '0;
         busy_q <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_baud) baud <= wdata;
         if (wr_ctrl) ctrl_q <= uart_ch_ctrl_t'(wdata[CTRL_W-1:0]);
         // a set event in the same cycle as a W1C keeps the bit set
         perr   <= parity_error | (perr & ~w1c_perr);
         done   <= busy_fall | (done & ~w1c_done);
         if (wr_cnt)
            errcnt <= {{(ERRCNT_W-1){1'b0}}, parity_error};
         else if (parity_error && (errcnt != '1))
            errcnt <= errcnt + ERRCNT_W'(1);
         busy_q <= busy;
         irq    <= (perr & ctrl_q.irq_perr_en) | (done & ctrl_q.irq_done_en);
      end
   end

endmodule

// File: rtl/uart_csr_multi_regfile.sv
// Host-bus CSR block for NUM_CH UART channels: request/response handshake,
// channel decode and read mux around an array of per-channel slices.
module uart_csr_multi_regfile
   import uart_csr_multi_regfile_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 32,
   parameter int BAUD_W   = 16,
   parameter int BAUD_RST = 434,
   parameter int ADDR_W   = $clog2(NUM_CH) + 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic [NUM_CH*BAUD_W-1:0] cfg_baud_div,
   output logic [NUM_CH-1:0]        cfg_enable,
   output logic [NUM_CH-1:0]        cfg_parity_en,
   output logic [NUM_CH-1:0]        cfg_parity_odd,
   output logic [NUM_CH-1:0]        cfg_stop2,
   input  logic [NUM_CH-1:0]        parity_error,
   input  logic [NUM_CH-1:0]        busy,
   input  logic [NUM_CH-1:0]        free,
   output logic [NUM_CH-1:0]        irq,
   output logic                     irq_any
);

   logic [ADDR_W-1:0]                 ch_idx;
   logic [1:0]                        reg_sel;
   logic                              addr_ok, accept;
   logic [DATA_W-1:0]                 rd_data;
   logic [NUM_CH-1:0][BAUD_W-1:0]     baud;
   logic [NUM_CH-1:0][CTRL_W-1:0]     ctrl;
   logic [NUM_CH-1:0][ERRCNT_W-1:0]   errcnt;
   logic [NUM_CH-1:0]                 perr, done;
   logic                              unused_wdata;

   // ch_idx keeps the full address width so a non-power-of-2 NUM_CH decodes
   assign ch_idx       = req_addr >> 2;
   assign reg_sel      = req_addr[1:0];
   assign addr_ok      = ch_idx < ADDR_W'(NUM_CH);
   assign req_ready    = !rsp_valid || rsp_ready;
   assign accept       = req_valid && req_ready;
   assign irq_any      = |irq;
   assign cfg_baud_div = baud;
   assign unused_wdata = ^req_wdata;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      uart_csr_chan #(.BAUD_W(BAUD_W), .BAUD_RST(BAUD_RST)) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .wr_en        (accept && req_write && addr_ok && (ch_idx == ADDR_W'(c))),
         .wr_reg       (reg_sel),
         .wdata        (req_wdata[BAUD_W-1:0]),
         .parity_error (parity_error[c]),
         .busy         (busy[c]),
         .baud         (baud[c]),
         .ctrl         (ctrl[c]),
         .perr         (perr[c]),
         .done         (done[c]),
         .errcnt       (errcnt[c]),
         .irq          (irq[c])
      );
      assign cfg_enable[c]     = ctrl[c][CTRL_ENABLE];
      assign cfg_parity_en[c]  = ctrl[c][CTRL_PARITY_EN];
      assign cfg_parity_odd[c] = ctrl[c][CTRL_PARITY_ODD];
      assign cfg_stop2[c]      = ctrl[c][CTRL_STOP2];
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_idx == ADDR_W'(c)) begin
            case (reg_sel)
               REG_BAUD:   rd_data = DATA_W'(baud[c]);
               REG_CTRL:   rd_data = DATA_W'(ctrl[c]);
               REG_STATUS: rd_data = DATA_W'({done[c], perr[c], free[c], busy[c]});
               default:    rd_data = DATA_W'(errcnt[c]);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_err   <= !addr_ok;
         rsp_rdata <= (!req_write && addr_ok) ? rd_data : '0;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_csr_multi_regfile.sv
// Scoreboard bench: a register-map model predicts every response and the
// cfg/irq outputs; a negedge monitor compares them against the DUT.
module tb_uart_csr_multi_regfile;

   localparam int NC = 3;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req_valid, req_ready, req_write;
   logic [AW-1:0]   req_addr;
   logic [31:0]     req_wdata;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [31:0]     rsp_rdata;
   logic [NC*16-1:0] cfg_baud_div;
   logic [NC-1:0]   cfg_enable, cfg_parity_en, cfg_parity_odd, cfg_stop2;
   logic [NC-1:0]   parity_error, busy, free, irq;
   logic            irq_any;

   always #5 clk = ~clk;

   uart_csr_multi_regfile #(.NUM_CH(NC), .DATA_W(32), .BAUD_W(16), .BAUD_RST(434), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .cfg_baud_div(cfg_baud_div), .cfg_enable(cfg_enable), .cfg_parity_en(cfg_parity_en),
      .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
      .parity_error(parity_error), .busy(busy), .free(free),
      .irq(irq), .irq_any(irq_any)
   );

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] rdata; logic err; } exp_t;
   exp_t        sb[$];
   logic [15:0] m_baud[NC];
   logic [5:0]  m_ctrl[NC];
   bit          m_perr[NC], m_done[NC], m_bhist[NC];
   int          m_cnt[NC];
   logic [NC-1:0] m_irq;
   bit          m_rv;

   always @(posedge clk or negedge rst_n) begin
      bit   acc, wr;
      int   ch, rg;
      exp_t e;
      if (!rst_n) begin
         for (int c = 0; c < NC; c++) begin
            m_baud[c] = 16'd434; m_ctrl[c] = '0; m_perr[c] = 0;
            m_done[c] = 0; m_bhist[c] = 0; m_cnt[c] = 0;
         end
         m_irq = '0; m_rv = 0; sb.delete();
      end else begin
         acc = req_valid && (!m_rv || rsp_ready);
         ch  = int'(req_addr) / 4;
         rg  = int'(req_addr) % 4;
         if (acc) begin
            e.err = (ch >= NC); e.rdata = '0;
            if (!req_write && ch < NC) begin
               case (rg)
                  0: e.rdata = {16'd0, m_baud[ch]};
                  1: e.rdata = {26'd0, m_ctrl[ch]};
                  2: e.rdata = {28'd0, m_done[ch], m_perr[ch], free[ch], busy[ch]};
                  default: e.rdata = m_cnt[ch];
               endcase
            end
            sb.push_back(e);
         end
         for (int c = 0; c < NC; c++) begin
            m_irq[c] = (m_perr[c] && m_ctrl[c][4]) || (m_done[c] && m_ctrl[c][5]);
            wr = acc && req_write && (ch == c);
            if (wr && rg == 0) m_baud[c] = req_wdata[15:0];
            if (wr && rg == 1) m_ctrl[c] = req_wdata[5:0];
            if (parity_error[c]) m_perr[c] = 1;
            else if (wr && rg == 2 && req_wdata[2]) m_perr[c] = 0;
            if (m_bhist[c] && !busy[c]) m_done[c] = 1;
            else if (wr && rg == 2 && req_wdata[3]) m_done[c] = 0;
            if (wr && rg == 3) m_cnt[c] = parity_error[c] ? 1 : 0;
            else if (parity_error[c] && m_cnt[c] < 255) m_cnt[c]++;
            m_bhist[c] = busy[c];
         end
         m_rv = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_rv);
      end
   end

   // ---------------- monitor ----------------
   logic [31:0]   prev_rdata;
   logic          prev_err;
   bit            prev_hold = 0;
   logic [NC-1:0] e_en, e_pen, e_odd, e_st2;
   logic [NC*16-1:0] e_baud;
   exp_t          got;

   always @(negedge clk) begin
      if (!rst_n) prev_hold = 0;
      else begin
         for (int c = 0; c < NC; c++) begin
            e_en[c] = m_ctrl[c][0]; e_pen[c] = m_ctrl[c][1];
            e_odd[c] = m_ctrl[c][2]; e_st2[c] = m_ctrl[c][3];
            e_baud[c*16 +: 16] = m_baud[c];
         end
         chk("rsp_valid", rsp_valid, m_rv);
         if (req_valid) chk("req_ready", req_ready, !m_rv || rsp_ready);
         chk("irq", irq, m_irq);
         chk("irq_any", irq_any, |m_irq);
         chk("cfg_baud_div", cfg_baud_div, e_baud);
         chk("cfg_ctrl", {cfg_stop2, cfg_parity_odd, cfg_parity_en, cfg_enable}, {e_st2, e_odd, e_pen, e_en});
         if (prev_hold) begin
            chk("rsp_hold_rdata", rsp_rdata, prev_rdata);
            chk("rsp_hold_err", rsp_err, prev_err);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL rsp_unexpected: got response 0x%0h with nothing outstanding at %0t", rsp_rdata, $time);
            end else begin
               got = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, got.rdata);
               chk("rsp_err", rsp_err, got.err);
            end
         end
         prev_hold  = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
         prev_err   = rsp_err;
      end
   end

   // ---------------- stimulus ----------------
   bit rnd = 0;

   task automatic bus(input bit w, input int a, input logic [31:0] d,
                      input logic [NC-1:0] pe = '0, input int hold = 0);
      int cnt = 0;
      bit acc;
      req_valid = 1; req_write = w; req_addr = a[AW-1:0]; req_wdata = d;
      parity_error = pe;
      forever begin
         if (rnd) rsp_ready = 1'($urandom);
         else if (cnt >= hold) rsp_ready = 1;
         @(negedge clk); acc = req_ready;
         @(posedge clk); #1;
         if (acc) break;
         cnt++;
         if (cnt > 200) begin
            n_checks++;
            $display("FAIL accept_timeout: request addr %0d never accepted", a);
            break;
         end
      end
      req_valid = 0; parity_error = '0;
   endtask

   task automatic idle(input int n, input logic [NC-1:0] pe = '0);
      repeat (n) begin
         parity_error = pe;
         @(posedge clk); #1;
      end
      parity_error = '0;
   endtask

   task automatic read_all();
      for (int ch = 0; ch <= NC; ch++)
         for (int r = 0; r < 4; r++) bus(0, ch * 4 + r, '0);
   endtask

   initial begin
      rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1; parity_error = '0; busy = 3'b010; free = 3'b101;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_irq", irq, 0);
      chk("rst_baud", cfg_baud_div, {3{16'd434}});
      chk("rst_enable", cfg_enable, 0);
      rst_n = 1;
      idle(1);
      read_all();

      // baud write and readback on channel 1
      bus(1, 4, 32'h1B2); bus(0, 4, '0); bus(0, 0, '0);

      // sticky perr with interrupt, W1C racing a new pulse
      bus(1, 9, 32'h10);
      idle(1, 3'b100); idle(2); bus(0, 10, '0);
      bus(1, 10, 32'h4, 3'b100); idle(2); bus(0, 10, '0);
      bus(1, 10, 32'h4); idle(2); bus(0, 10, '0);

      // error counter saturation and clear
      idle(300, 3'b001); bus(0, 3, '0);
      bus(1, 3, '0); bus(0, 3, '0);
      bus(1, 3, 32'hFF, 3'b001); bus(0, 3, '0);

      // back-pressure then back-to-back
      idle(1); rsp_ready = 0;
      bus(0, 4, '0, '0, 1); bus(0, 0, '0, '0, 6);
      bus(0, 1, '0); bus(0, 2, '0); bus(0, 13, '0);

      // busy falling edge -> done
      bus(1, 1, 32'h2F); busy[0] = 1; idle(2); busy[0] = 0; idle(2);
      bus(0, 2, '0); bus(1, 2, 32'h8); idle(1); bus(0, 2, '0);

      rnd = 1;
      repeat (250) begin
         busy = 3'($urandom); free = 3'($urandom);
         bus(1'($urandom), int'($urandom_range(0, 15)), $urandom, 3'($urandom), 0);
      end
      rnd = 0; rsp_ready = 1; busy = '0; idle(3);

      // reset while a response is held
      rsp_ready = 0; bus(0, 4, '0, '0, 1);
      rst_n = 0; #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_irq", irq, 0);
      chk("midrst_baud", cfg_baud_div, {3{16'd434}});
      rsp_ready = 1; idle(2); rst_n = 1; idle(1);
      read_all();
      idle(3);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
